// File: rtl/ram_arb_pkg.sv
// Shared types and window defaults for the data-RAM port arbiter.
// States, address regions and requester id.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_e;

  typedef enum logic [1:0] {
    REG_NONE,
    REG_DATA,
    REG_STACK
  } region_e;

  typedef logic req_id_t;

  localparam logic [31:0] DEF_DATA_BASE   = 32'h0000_1000;
  localparam int unsigned DEF_DATA_WORDS  = 100;
  localparam logic [31:0] DEF_STACK_TOP   = 32'hFFFF_FFFC;
  localparam int unsigned DEF_STACK_WORDS = 10;

endpackage

// File: rtl/ram_addr_check.sv
// Address legality check for the data RAM window.
// Bounds use 33-bit arithmetic so the stack top cannot wrap to 0.
module ram_addr_check
  import ram_arb_pkg::*;
#(
  parameter logic [31:0] DATA_BASE   = DEF_DATA_BASE,
  parameter int unsigned DATA_WORDS  = DEF_DATA_WORDS,
  parameter logic [31:0] STACK_TOP   = DEF_STACK_TOP,
  parameter int unsigned STACK_WORDS = DEF_STACK_WORDS
) (
  input  logic [31:0] addr,
  output logic        legal,
  output region_e     region
);

  localparam logic [32:0] D_LO = {1'b0, DATA_BASE};
  localparam logic [32:0] D_HI = D_LO + 33'(4 * DATA_WORDS) - 33'd4;
  localparam logic [32:0] S_HI = {1'b0, STACK_TOP};
  localparam logic [32:0] S_LO = S_HI - 33'(4 * (STACK_WORDS - 1));

  logic [32:0] a;
  logic        aligned;
  logic        in_data;
  logic        in_stack;

  // Classify the address into data window, stack window or neither.
  always_comb begin
    a        = {1'b0, addr};
    aligned  = (addr[1:0] == 2'b00);
    in_data  = (a >= D_LO) && (a <= D_HI);
    in_stack = (a >= S_LO) && (a <= S_HI);
    region   = REG_NONE;
    if (aligned && in_data) begin
      region = REG_DATA;
    end else if (aligned && in_stack) begin
      region = REG_STACK;
    end
    legal = (region != REG_NONE);
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Two-requester arbiter in front of the single data-RAM port.
// One access per two cycles, registered completion and read data.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter logic [31:0] DATA_BASE   = DEF_DATA_BASE,
  parameter int unsigned DATA_WORDS  = DEF_DATA_WORDS,
  parameter logic [31:0] STACK_TOP   = DEF_STACK_TOP,
  parameter int unsigned STACK_WORDS = DEF_STACK_WORDS,
  parameter bit          FIXED_PRIO  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       m_req,
  input  logic [1:0]       m_we,
  input  logic [1:0][31:0] m_addr,
  input  logic [1:0][31:0] m_wdata,
  output logic [1:0]       m_gnt,
  output logic [1:0]       m_done,
  output logic [1:0]       m_err,
  output logic [31:0]      m_rdata,
  output logic             mem_write,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata
);

  state_e      state_q, state_d;
  req_id_t     id_q, id_d;
  req_id_t     last_q, last_d;
  req_id_t     win;
  logic        we_q, we_d;
  logic        legal_q, legal_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  done_q, done_d;
  logic [1:0]  err_q, err_d;
  logic        chk_legal;
  region_e     chk_region;
  logic        win_legal;

  // Pick the winner: sole requester, else fixed M0 or the one not granted last.
  always_comb begin
    if (m_req == 2'b11) begin
      win = FIXED_PRIO ? 1'b0 : ~last_q;
    end else begin
      win = m_req[1];
    end
  end

  ram_addr_check #(
    .DATA_BASE  (DATA_BASE),
    .DATA_WORDS (DATA_WORDS),
    .STACK_TOP  (STACK_TOP),
    .STACK_WORDS(STACK_WORDS)
  ) u_chk (
    .addr  (m_addr[win]),
    .legal (chk_legal),
    .region(chk_region)
  );

  assign win_legal = chk_legal & (chk_region != REG_NONE);

  // Next state, capture and response logic.
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    last_d  = last_q;
    we_d    = we_q;
    legal_d = legal_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    done_d  = 2'b00;
    err_d   = 2'b00;
    m_gnt   = 2'b00;
    unique case (state_q)
      IDLE, RESP: begin
        state_d = IDLE;
        if (|m_req && !rst) begin
          m_gnt[win] = 1'b1;
          id_d       = win;
          last_d     = win;
          we_d       = m_we[win];
          legal_d    = win_legal;
          addr_d     = win_legal ? m_addr[win] : DATA_BASE;
          wdata_d    = m_wdata[win];
          state_d    = ACCESS;
        end
      end
      ACCESS: begin
        done_d[id_q] = 1'b1;
        err_d[id_q]  = ~legal_q;
        if (legal_q && !we_q) begin
          rdata_d = mem_rdata;
        end
        state_d = RESP;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and capture registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      id_q    <= 1'b0;
      last_q  <= 1'b1;
      we_q    <= 1'b0;
      legal_q <= 1'b0;
      addr_q  <= DATA_BASE;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      done_q  <= 2'b00;
      err_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      last_q  <= last_d;
      we_q    <= we_d;
      legal_q <= legal_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign mem_write = (state_q == ACCESS) & we_q & legal_q & ~rst;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign m_done    = done_q;
  assign m_err     = err_q;
  assign m_rdata   = rdata_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: directed scenarios plus random traffic
// against a word-level memory model; second instance uses fixed priority.
module tb_ram_port_arbiter;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [1:0]       m_req = 2'b00;
  logic [1:0]       m_we = 2'b00;
  logic [1:0][31:0] m_addr = '0;
  logic [1:0][31:0] m_wdata = '0;

  logic [1:0]  m_gnt, m_done, m_err;
  logic [31:0] m_rdata, mem_addr, mem_wdata;
  logic        mem_write;
  logic [31:0] mem_rdata = 32'h0;

  logic [1:0]  f_gnt, f_done, f_err;
  logic [31:0] f_rdata, f_mem_addr, f_mem_wdata;
  logic        f_mem_write;
  logic [31:0] f_mem_rdata = 32'h0;

  always #5 clk = ~clk;

  ram_port_arbiter #(.FIXED_PRIO(1'b0)) dut (
    .clk(clk), .rst(rst),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_gnt(m_gnt), .m_done(m_done), .m_err(m_err), .m_rdata(m_rdata),
    .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  ram_port_arbiter #(.FIXED_PRIO(1'b1)) dut_fp (
    .clk(clk), .rst(rst),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_gnt(f_gnt), .m_done(f_done), .m_err(f_err), .m_rdata(f_rdata),
    .mem_write(f_mem_write), .mem_addr(f_mem_addr),
    .mem_wdata(f_mem_wdata), .mem_rdata(f_mem_rdata)
  );

  int pass_n = 0;
  int tot_n = 0;
  int cyc = 0;
  int wr_cnt = 0;
  int wr_cyc = -1;
  int bad_addr = 0;
  int last_m = 1;
  logic [31:0] cur_rd = 32'h0;
  logic [31:0] ram0 [0:109];
  logic [31:0] ram1 [0:109];
  logic [31:0] mdl [0:109];

  function automatic bit ref_legal(input logic [31:0] a);
    longint x;
    x = longint'(a);
    if (x % 4 != 0) return 1'b0;
    if (x >= 64'h1000 && x <= 64'h1000 + 4 * 100 - 4) return 1'b1;
    if (x >= 64'hFFFF_FFFC - 4 * 9 && x <= 64'hFFFF_FFFC) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int ridx(input logic [31:0] a);
    if (!ref_legal(a)) return -1;
    if (a < 32'h2000) return int'((a - 32'h1000) >> 2);
    return 100 + int'((a - 32'hFFFF_FFD8) >> 2);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural RAM: writes on negedge, read value presented for next posedge.
  always @(negedge clk) begin
    if (mem_write) begin
      if (ridx(mem_addr) >= 0) ram0[ridx(mem_addr)] <= mem_wdata;
      wr_cnt <= wr_cnt + 1;
      wr_cyc <= cyc;
    end
    if (!rst && ridx(mem_addr) < 0) bad_addr <= bad_addr + 1;
    if (mem_write) mem_rdata <= mem_wdata;
    else if (ridx(mem_addr) >= 0) mem_rdata <= ram0[ridx(mem_addr)];
    else mem_rdata <= 32'hBAD0_BAD0;
  end

  always @(negedge clk) begin
    if (f_mem_write && ridx(f_mem_addr) >= 0) ram1[ridx(f_mem_addr)] <= f_mem_wdata;
    if (f_mem_write) f_mem_rdata <= f_mem_wdata;
    else if (ridx(f_mem_addr) >= 0) f_mem_rdata <= ram1[ridx(f_mem_addr)];
    else f_mem_rdata <= 32'hBAD0_BAD0;
  end

  task automatic do_access(input int id, input bit we, input logic [31:0] addr,
                           input logic [31:0] wdata, input string tag);
    int gc, dc, w0, idx;
    bit got, exp_err, exp_wr;
    logic [31:0] exp_rd;
    idx = ridx(addr);
    exp_err = (idx < 0);
    exp_wr = we && !exp_err;
    exp_rd = (we || exp_err) ? cur_rd : mdl[idx];
    w0 = wr_cnt;
    gc = 0;
    dc = 0;
    @(negedge clk);
    m_req[id] = 1'b1;
    m_we[id] = we;
    m_addr[id] = addr;
    m_wdata[id] = wdata;
    got = 0;
    for (int k = 0; k < 10 && !got; k++) begin
      #1;
      if (m_gnt[id]) begin
        got = 1;
        gc = cyc;
      end else begin
        @(negedge clk);
      end
    end
    tot_n++;
    if (!got) $display("FAIL %s gnt: not seen, required within 10 cycles", tag);
    else pass_n++;
    @(posedge clk);
    #1 m_req[id] = 1'b0;
    got = 0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk);
      #1;
      if (m_done[id]) begin
        got = 1;
        dc = cyc;
      end
    end
    tot_n++;
    if (dc - gc != 2) $display("FAIL %s latency: got %0d required 2", tag, dc - gc);
    else pass_n++;
    tot_n++;
    if (m_err[id] !== exp_err) $display("FAIL %s err: got %b required %b", tag, m_err[id], exp_err);
    else pass_n++;
    tot_n++;
    if (m_rdata !== exp_rd) $display("FAIL %s rdata: got %h required %h", tag, m_rdata, exp_rd);
    else pass_n++;
    tot_n++;
    if (wr_cnt - w0 != int'(exp_wr))
      $display("FAIL %s writes: got %0d required %0d", tag, wr_cnt - w0, int'(exp_wr));
    else pass_n++;
    if (exp_wr) begin
      tot_n++;
      if (wr_cyc != gc + 1) $display("FAIL %s wr_cycle: got %0d required %0d", tag, wr_cyc, gc + 1);
      else pass_n++;
      mdl[idx] = wdata;
    end
    if (!we && !exp_err) cur_rd = mdl[idx];
    last_m = id;
  endtask

  task automatic check_idle_outputs(input string tag);
    tot_n++;
    if ({m_gnt, m_done, m_err} !== 6'b0)
      $display("FAIL %s flags: got %b required 000000", tag, {m_gnt, m_done, m_err});
    else pass_n++;
    tot_n++;
    if (m_rdata !== 32'h0) $display("FAIL %s rdata: got %h required 0", tag, m_rdata);
    else pass_n++;
    tot_n++;
    if (mem_write !== 1'b0 || mem_addr !== 32'h1000 || mem_wdata !== 32'h0)
      $display("FAIL %s mem: got %b %h %h required 0 00001000 0", tag, mem_write, mem_addr, mem_wdata);
    else pass_n++;
    tot_n++;
    if ({f_gnt, f_done, f_err, f_mem_write} !== 7'b0 || f_mem_addr !== 32'h1000)
      $display("FAIL %s fp_outputs: got %b %h required 0 00001000", tag,
               {f_gnt, f_done, f_err, f_mem_write}, f_mem_addr);
    else pass_n++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    #1;
    check_idle_outputs("reset");
  endtask

  task automatic test_store_load();
    do_access(0, 1'b1, 32'h1004, 32'hDEAD_BEEF, "st_1004");
    do_access(0, 1'b0, 32'h1004, 32'h0, "ld_1004");
    tot_n++;
    if (m_rdata !== 32'hDEAD_BEEF) $display("FAIL ld_value: got %h required deadbeef", m_rdata);
    else pass_n++;
  endtask

  task automatic test_illegal();
    int diffs;
    do_access(0, 1'b1, 32'h1190, 32'h1111_1111, "ill_1190");
    do_access(1, 1'b1, 32'h1002, 32'h2222_2222, "ill_1002");
    do_access(0, 1'b1, 32'hFFFF_FFD4, 32'h3333_3333, "ill_ffd4");
    do_access(1, 1'b0, 32'h0000_0000, 32'h0, "ill_ld_0");
    diffs = 0;
    for (int i = 0; i < 110; i++) if (ram0[i] !== mdl[i]) diffs++;
    tot_n++;
    if (diffs != 0) $display("FAIL ram_image: got %0d differing words required 0", diffs);
    else pass_n++;
    do_access(0, 1'b1, 32'hFFFF_FFD8, 32'h4444_4444, "st_ffd8");
    do_access(1, 1'b1, 32'h0000_118C, 32'h5555_5555, "st_118c");
  endtask

  task automatic test_stack();
    do_access(1, 1'b1, 32'hFFFF_FFFC, 32'h1234_5678, "st_fffc");
    do_access(0, 1'b0, 32'hFFFF_FFFC, 32'h0, "ld_fffc");
    tot_n++;
    if (m_rdata !== 32'h1234_5678) $display("FAIL stack_value: got %h required 12345678", m_rdata);
    else pass_n++;
  endtask

  task automatic test_arbitration();
    int exp_id;
    logic [1:0] eg;
    logic [31:0] a[2];
    a[0] = 32'h1004;
    a[1] = 32'hFFFF_FFFC;
    exp_id = 1 - last_m;
    @(negedge clk);
    m_we = 2'b00;
    m_addr[0] = a[0];
    m_addr[1] = a[1];
    m_req = 2'b11;
    for (int k = 0; k < 12; k++) begin
      #1;
      eg = (k % 2 != 0) ? 2'b00 : ((exp_id == 0) ? 2'b01 : 2'b10);
      tot_n++;
      if (m_gnt !== eg) $display("FAIL rr_gnt[%0d]: got %b required %b", k, m_gnt, eg);
      else pass_n++;
      tot_n++;
      if (f_gnt !== ((k % 2 != 0) ? 2'b00 : 2'b01))
        $display("FAIL fixed_gnt[%0d]: got %b required %b", k, f_gnt,
                 (k % 2 != 0) ? 2'b00 : 2'b01);
      else pass_n++;
      if (k % 2 == 0) begin
        last_m = exp_id;
        exp_id = 1 - exp_id;
      end
      @(negedge clk);
    end
    m_req = 2'b00;
    repeat (3) @(negedge clk);
    cur_rd = mdl[ridx(a[last_m])];
    #1;
    tot_n++;
    if (m_rdata !== cur_rd) $display("FAIL rr_rdata: got %h required %h", m_rdata, cur_rd);
    else pass_n++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    bit got;
    int gc;
    d = $urandom;
    got = 0;
    gc = 0;
    @(negedge clk);
    m_req[0] = 1'b1;
    m_we[0] = 1'b1;
    m_addr[0] = 32'h1010;
    m_wdata[0] = d;
    for (int k = 0; k < 10 && !got; k++) begin
      #1;
      if (m_gnt[0]) begin
        got = 1;
        gc = cyc;
      end else begin
        @(negedge clk);
      end
    end
    @(posedge clk);
    #1 m_we[0] = 1'b0;
    @(negedge clk);
    #1;
    tot_n++;
    if (!got || m_gnt !== 2'b00) $display("FAIL b2b_access_gnt: got %b required 00", m_gnt);
    else pass_n++;
    @(negedge clk);
    #1;
    tot_n++;
    if (m_gnt !== 2'b01 || m_done !== 2'b01 || cyc != gc + 2)
      $display("FAIL b2b_resp: got gnt %b done %b cyc %0d required 01 01 %0d", m_gnt, m_done, cyc, gc + 2);
    else pass_n++;
    @(posedge clk);
    #1 m_req[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    tot_n++;
    if (m_done !== 2'b01 || m_err !== 2'b00 || m_rdata !== d)
      $display("FAIL b2b_load: got done %b err %b rdata %h required 01 00 %h", m_done, m_err, m_rdata, d);
    else pass_n++;
    mdl[ridx(32'h1010)] = d;
    cur_rd = d;
    last_m = 0;
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [31:0] edges[6];
    edges[0] = 32'h0000_1000;
    edges[1] = 32'h0000_0FFC;
    edges[2] = 32'h0000_118C;
    edges[3] = 32'h0000_1190;
    edges[4] = 32'hFFFF_FFD4;
    edges[5] = 32'h0000_0000;
    for (int n = 0; n < 40; n++) begin
      case ($urandom % 5)
        0: a = 32'h1000 + 4 * ($urandom % 100);
        1: a = 32'hFFFF_FFD8 + 4 * ($urandom % 10);
        2: a = 32'h1000 + 4 * ($urandom % 100) + 1 + ($urandom % 3);
        3: a = edges[$urandom % 6];
        default: a = $urandom & 32'hFFFF_FFFC;
      endcase
      do_access(int'($urandom % 2), 1'($urandom % 2), a, $urandom, $sformatf("rnd%0d", n));
    end
  endtask

  task automatic test_reset_mid();
    int w0;
    bit got;
    w0 = wr_cnt;
    got = 0;
    @(negedge clk);
    m_req[1] = 1'b1;
    m_we[1] = 1'b1;
    m_addr[1] = 32'h1100;
    m_wdata[1] = 32'hA5A5_A5A5;
    for (int k = 0; k < 10 && !got; k++) begin
      #1;
      if (m_gnt[1]) got = 1;
      else @(negedge clk);
    end
    @(posedge clk);
    #1;
    m_req[1] = 1'b0;
    rst = 1'b1;
    #1;
    tot_n++;
    if (!got || mem_write !== 1'b0) $display("FAIL rst_mid_write: got %b required 0", mem_write);
    else pass_n++;
    @(posedge clk);
    #1 rst = 1'b0;
    check_idle_outputs("rst_mid");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      tot_n++;
      if (m_done !== 2'b00) $display("FAIL rst_mid_done[%0d]: got %b required 00", k, m_done);
      else pass_n++;
    end
    tot_n++;
    if (wr_cnt != w0 || ram0[ridx(32'h1100)] !== mdl[ridx(32'h1100)])
      $display("FAIL rst_mid_ram: got %0d writes required 0", wr_cnt - w0);
    else pass_n++;
    cur_rd = 32'h0;
    last_m = 1;
  endtask

  initial begin
    for (int i = 0; i < 110; i++) begin
      ram0[i] = 32'h0;
      ram1[i] = 32'h0;
      mdl[i] = 32'h0;
    end
    test_reset();
    test_store_load();
    test_illegal();
    test_stack();
    test_arbitration();
    test_back_to_back();
    test_random();
    test_reset_mid();
    do_access(0, 1'b0, 32'h1004, 32'h0, "post_rst_ld");
    tot_n++;
    if (bad_addr != 0) $display("FAIL ram_addr_window: got %0d bad cycles required 0", bad_addr);
    else pass_n++;
    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end

endmodule
